x_uart_tx: RTL and testbench
============================

Name: x_uart_tx

Overview:
- UART transmitter that sits directly downstream of the byte driver stage.
- Consumes bytes over a valid/accept handshake and serialises each one onto a single TX line: 8N1 by default, LSB first.
- Gives the design's output path a serial pin, so a host can read back the bytes the driver unloads.

Parameters:
- CLK_DIV, 104: clock cycles per serial bit; legal range >= 2.
- STOP_BITS, 1: number of stop bits per frame; legal values 1 or 2.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream byte available; held until accepted.
- i_data  input  8  upstream byte; stable while i_valid is high.
- o_accept  output  1  one-cycle pulse; the byte on i_data is taken this cycle.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  high while a frame is in flight (any state other than IDLE).

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_tx=1, o_busy=0, o_accept=0, bit counter=0, baud counter=0, shift register=0.
- o_accept = (state==IDLE) & i_valid, combinational.
  - It never asserts outside IDLE.
  - Upstream advances its data on accept, so a spurious accept corrupts upstream data and is forbidden.
- Accept cycle: i_data latched into the shift register; state -> START on the next edge.
- States and transitions:
  - IDLE: o_tx=1. Go to START when o_accept.
  - START: o_tx=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles. Shift right after each bit; 3-bit bit counter. After bit 7 go to STOP (or PARITY when the optional feature is enabled).
  - STOP: o_tx=1 for STOP_BITS*CLK_DIV cycles, then IDLE.
- o_tx is driven from a flop. The first start-bit cycle is the cycle after the accept pulse.
- Baud counter:
  - Width $clog2(CLK_DIV); counts 0..CLK_DIV-1.
  - Wraps to 0 on each bit boundary.
  - Held at 0 in IDLE.
- Frame length is (1+8+STOP_BITS)*CLK_DIV cycles.
- Back-to-back frames:
  - At least one IDLE cycle separates frames (the accept cycle itself).
  - Accept-to-accept spacing is exactly frame length + 1 cycles when i_valid is held high.
- Upstream protocol:
  - i_valid may rise at any time; it is ignored while busy.
  - i_data changes while valid is high and unaccepted are not tracked; the value present in the accept cycle is sent.
- Reset mid-frame: the line returns high immediately (async) and the frame is truncated and dropped. No accept occurs until the cycle after reset release at the earliest.
- No back-pressure from the line and no FIFO: at most one byte is held in the block.

Optional Feature:
- Macro X_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - Drives one even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame length is (1+8+1+STOP_BITS)*CLK_DIV.
  - Parity is computed from the latched byte at accept, not from the shifting register.
- When undefined:
  - No PARITY state, no parity logic, frame as above.
  - The state encoding may omit the extra state.

Test Plan:
1. CLK_DIV=4, reset then idle 20 cycles -> o_tx=1, o_busy=0, o_accept=0 throughout.
2. CLK_DIV=4, i_valid=1 with i_data=0xA5 for one accept -> o_accept pulses once. Next 40 cycles o_tx = 0 (4 cycles) then 1,0,1,0,0,1,0,1 (4 cycles each) then 1 (4 cycles). o_busy high exactly those 40 cycles.
3. CLK_DIV=4, i_valid held high with bytes 0x00 then 0xFF (upstream advances on accept) -> accept pulses exactly 41 cycles apart. Second frame shows start 0, eight 1s, stop 1.
4. CLK_DIV=4, pulse i_rst_n low at cycle 15 of a 0x3C frame -> o_tx=1 asynchronously in the reset cycle, o_busy=0. After release with i_valid=1, a fresh full frame of the current byte starts.
5. i_valid raised while busy -> no o_accept until the cycle after the final stop bit. i_data changes before accept are not transmitted.
6. X_UART_TX_PARITY_EN defined, CLK_DIV=4 -> 0xA5 frame carries parity bit 0 and 0x07 frame carries parity bit 1. Each frame is 44 cycles; accept spacing is 45 cycles.

Source files
------------

// File: rtl/x_uart_tx.sv
// x_uart_tx: UART transmitter fed by a valid/accept byte handshake.
//
// Serialises each accepted byte onto o_tx as start bit, 8 data bits
// (LSB first), an optional even-parity bit, and STOP_BITS stop bits.
// Each bit is held for CLK_DIV clock cycles. Only one byte is held at a time.
//
// Optional feature: define X_UART_TX_PARITY_EN to insert one even-parity bit
// between the last data bit and the stop bit(s).
//
// Parameters:
//   CLK_DIV   clock cycles per serial bit (>= 2)
//   STOP_BITS stop bits per frame (1 or 2)
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   upstream byte available, held until accepted
//   i_data    upstream byte
//   o_accept  one-cycle pulse: i_data is taken this cycle
//   o_tx      serial line, idles high, driven from a flop
//   o_busy    high while a frame is in flight
module x_uart_tx #(
  parameter int CLK_DIV   = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int              BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]   BAUD_MAX  = BW'(CLK_DIV - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef X_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef X_UART_TX_PARITY_EN
  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  state_t        state_r;
  state_t        state_next_s;
  logic [BW-1:0] baud_r;
  logic [BW-1:0] baud_next_s;
  logic [2:0]    bit_cnt_r;
  logic [2:0]    bit_cnt_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic          tx_r;
  logic          tx_next_s;
  logic          busy_r;
  logic          ready_r;
  logic          baud_last_s;
  logic          accept_s;
`ifdef X_UART_TX_PARITY_EN
  logic          parity_r;
  logic          parity_next_s;
`endif

  // ready_r keeps accept low until the first edge after reset release.
  assign accept_s    = (state_r == ST_IDLE) & i_valid & ready_r;
  assign baud_last_s = (baud_r == BAUD_MAX);

  assign o_accept = accept_s;
  assign o_tx     = tx_r;
  assign o_busy   = busy_r;

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    state_next_s   = state_r;
    baud_next_s    = baud_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    tx_next_s      = tx_r;
`ifdef X_UART_TX_PARITY_EN
    parity_next_s  = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        tx_next_s      = 1'b1;
        baud_next_s    = '0;
        bit_cnt_next_s = 3'd0;
        if (accept_s) begin
          shift_next_s  = i_data;
`ifdef X_UART_TX_PARITY_EN
          parity_next_s = even_parity(i_data);
`endif
          state_next_s  = ST_START;
          tx_next_s     = 1'b0;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          // Present bit 0 and pre-shift so shift_r[0] is always the next bit.
          baud_next_s    = '0;
          state_next_s   = ST_DATA;
          tx_next_s      = shift_r[0];
          shift_next_s   = {1'b0, shift_r[7:1]};
          bit_cnt_next_s = 3'd0;
        end else begin
          baud_next_s    = baud_r + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_next_s = '0;
          if (bit_cnt_r == 3'd7) begin
            bit_cnt_next_s = 3'd0;
`ifdef X_UART_TX_PARITY_EN
            state_next_s   = ST_PARITY;
            tx_next_s      = parity_r;
`else
            state_next_s   = ST_STOP;
            tx_next_s      = 1'b1;
`endif
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
            tx_next_s      = shift_r[0];
            shift_next_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
`ifdef X_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last_s) begin
          baud_next_s    = '0;
          bit_cnt_next_s = 3'd0;
          state_next_s   = ST_STOP;
          tx_next_s      = 1'b1;
        end else begin
          baud_next_s    = baud_r + BW'(1);
        end
      end
`endif
      ST_STOP: begin
        tx_next_s = 1'b1;
        if (baud_last_s) begin
          baud_next_s = '0;
          // bit_cnt_r counts stop bits here.
          if (bit_cnt_r == STOP_LAST) begin
            bit_cnt_next_s = 3'd0;
            state_next_s   = ST_IDLE;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        tx_next_s      = 1'b1;
        baud_next_s    = '0;
        bit_cnt_next_s = 3'd0;
        shift_next_s   = 8'd0;
      end
    endcase
  end

  // Sequencer state, counters, shift register and output flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      baud_r    <= '0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef X_UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      baud_r    <= baud_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= shift_next_s;
      tx_r      <= tx_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
`ifdef X_UART_TX_PARITY_EN
      parity_r  <= parity_next_s;
`endif
    end
  end

  // Accept enable that stays low until the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_x_uart_tx.sv
// Testbench for x_uart_tx (CLK_DIV=4, STOP_BITS=1). Builds the expected line
// waveform of each frame from the byte value and compares o_tx, o_busy and
// o_accept every cycle. Honours X_UART_TX_PARITY_EN for the frame layout.
module tb_x_uart_tx;

  localparam int CLK_DIV   = 4;
  localparam int STOP_BITS = 1;
`ifdef X_UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME = (1 + 8 + PAR_BITS + STOP_BITS) * CLK_DIV;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       o_accept;
  logic       o_tx;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int last_acc = 0;
  bit exp_bits[$];

  x_uart_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(STOP_BITS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_accept(o_accept),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line bits of one frame, one entry per serial bit.
  function automatic void build_frame(input logic [7:0] b);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (PAR_BITS == 1) exp_bits.push_back(^b);
    for (int i = 0; i < STOP_BITS; i++) exp_bits.push_back(1'b1);
  endfunction

  // Offer byte b, expect it accepted now, then check ncyc frame cycles.
  task automatic run_frame(input logic [7:0] b, input bit hold, input bit chained, input int ncyc);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = b;
    #1;
    chk("accept", o_accept, 8'd1);
    chk("accept_busy", o_busy, 8'd0);
    chk("accept_tx", o_tx, 8'd1);
    if (chained) chk("spacing", 8'(cyc_cnt - last_acc), 8'(FRAME + 1));
    last_acc = cyc_cnt;
    build_frame(b);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge i_clk);
      i_valid = hold;
      i_data  = 8'($urandom);
      #1;
      chk("tx", o_tx, 8'(exp_bits[k / CLK_DIV]));
      chk("busy", o_busy, 8'd1);
      chk("no_accept", o_accept, 8'd0);
    end
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      chk("idle_tx", o_tx, 8'd1);
      chk("idle_busy", o_busy, 8'd0);
      chk("idle_accept", o_accept, 8'd0);
    end
  endtask

  initial begin
    // Reset state.
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_tx", o_tx, 8'd1);
    chk("rst_busy", o_busy, 8'd0);
    chk("rst_accept", o_accept, 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_check(20);

    // Single frame 0xA5, then line returns to idle.
    run_frame(8'hA5, 1'b0, 1'b0, FRAME);
    idle_check(3);

    // Back-to-back with valid held; data wiggles while busy.
    run_frame(8'h00, 1'b1, 1'b0, FRAME);
    run_frame(8'hFF, 1'b1, 1'b1, FRAME);
    run_frame(8'h07, 1'b1, 1'b1, FRAME);
    run_frame(8'hA5, 1'b1, 1'b1, FRAME);
    for (int r = 0; r < 4; r++) begin
      run_frame(8'($urandom), 1'b1, 1'b1, FRAME);
    end

    // Reset while the line is low in the middle of a 0x3C frame.
    run_frame(8'h3C, 1'b1, 1'b1, 7);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'h3C;
    #1;
    chk("midrst_tx", o_tx, 8'd1);
    chk("midrst_busy", o_busy, 8'd0);
    chk("midrst_accept", o_accept, 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("release_accept", o_accept, 8'd0);
    chk("release_tx", o_tx, 8'd1);
    run_frame(8'h3C, 1'b0, 1'b0, FRAME);
    idle_check(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
